// File: rtl/store_drain_buffer.sv
// Store drain buffer: queues committed stores and drains them in order to the Dmem port.
// Optional macro STORE_FWD_EN enables store-to-load lookup against pending entries.
module store_drain_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  ret_command,
  input  logic [1:0]  ret_size,
  input  logic [31:0] ret_addr,
  input  logic [31:0] ret_data,
  output logic        sb_full,
  output logic        sb_empty,
  output logic        overflow,
  input  logic        load_busy,
  output logic [1:0]  proc2Dmem_command,
  output logic [1:0]  proc2Dmem_size,
  output logic [31:0] proc2Dmem_addr,
  output logic [31:0] proc2Dmem_data,
  input  logic [3:0]  Dmem2proc_response,
  input  logic [31:0] lookup_addr,
  input  logic [1:0]  lookup_size,
  output logic        lookup_hit,
  output logic [31:0] lookup_data,
  output logic        lookup_conflict
);

  localparam int XLEN  = 32;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             overflow_q;

  logic [XLEN-1:0] addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [1:0]      size_q [DEPTH];

  logic is_store;
  logic enq;
  logic issue;
  logic deq;

  assign sb_full  = (count == FULL_CNT);
  assign sb_empty = (count == '0);
  assign overflow = overflow_q;

  assign is_store = (ret_command == BUS_STORE);
  assign enq      = is_store && !sb_full;

  // Memory handshake: the head entry is offered (valid) whenever the buffer is
  // non-empty and the load unit does not own the bus; a non-zero response in
  // that cycle is the ready/accept, and only then does the head advance.
  // Without an accept the identical entry is offered again next cycle.
  assign issue = !sb_empty && !load_busy;
  assign deq   = issue && (Dmem2proc_response != 4'h0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(1);
      end
      if (deq) begin
        head <= head + PTR_W'(1);
      end
      unique case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      // Full is judged on registered count, so a same-cycle drain does not rescue the store.
      if (is_store && sb_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else if (enq) begin
      addr_q[tail] <= ret_addr;
      data_q[tail] <= ret_data;
      size_q[tail] <= ret_size;
    end
  end

  assign proc2Dmem_command = issue ? BUS_STORE : BUS_NONE;
  assign proc2Dmem_addr    = sb_empty ? '0 : addr_q[head];
  assign proc2Dmem_data    = sb_empty ? '0 : data_q[head];
  assign proc2Dmem_size    = sb_empty ? '0 : size_q[head];

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] idx;
  logic [XLEN:0]    ld_lo;
  logic [XLEN:0]    ld_hi;
  logic [XLEN:0]    st_lo;
  logic [XLEN:0]    st_hi;
  logic             exact;
  logic             overlap;
  logic             fwd_hit;
  logic [XLEN-1:0]  fwd_data;
  logic             fwd_conflict;

  function automatic logic [XLEN:0] size_bytes(input logic [1:0] sz);
    logic [3:0] nb;
    nb = 4'd1 << sz;
    return {{(XLEN-3){1'b0}}, nb};
  endfunction

  // Walk oldest to youngest so the last exact match seen is the youngest one.
  // Exact matches never block; any partial overlap does.
  always_comb begin
    idx          = '0;
    st_lo        = '0;
    st_hi        = '0;
    exact        = 1'b0;
    overlap      = 1'b0;
    fwd_hit      = 1'b0;
    fwd_data     = '0;
    fwd_conflict = 1'b0;
    ld_lo        = {1'b0, lookup_addr};
    ld_hi        = ld_lo + size_bytes(lookup_size);
    for (int i = 0; i < DEPTH; i++) begin
      idx     = head + PTR_W'(i);
      st_lo   = {1'b0, addr_q[idx]};
      st_hi   = st_lo + size_bytes(size_q[idx]);
      exact   = (addr_q[idx] == lookup_addr) && (size_q[idx] == lookup_size);
      overlap = (st_lo < ld_hi) && (ld_lo < st_hi);
      if ((PTR_W+1)'(i) < count) begin
        if (exact) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[idx];
        end else if (overlap) begin
          fwd_conflict = 1'b1;
        end
      end
    end
  end

  assign lookup_conflict = fwd_conflict;
  assign lookup_hit      = fwd_hit && !fwd_conflict;
  assign lookup_data     = (fwd_hit && !fwd_conflict) ? fwd_data : '0;
`else
  logic unused_lookup;
  assign unused_lookup   = ^{lookup_addr, lookup_size};

  // Without forwarding, any pending store holds off every load.
  assign lookup_hit      = 1'b0;
  assign lookup_data     = '0;
  assign lookup_conflict = !sb_empty;
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: drain order, retry, full/overflow, load_busy, lookup, async reset.
module tb_store_drain_buffer;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_STORE = 2'h2;
  localparam logic [1:0] SZ_HALF   = 2'h1;
  localparam logic [1:0] SZ_WORD   = 2'h2;

  logic        clock;
  logic        reset;
  logic [1:0]  ret_command;
  logic [1:0]  ret_size;
  logic [31:0] ret_addr;
  logic [31:0] ret_data;
  logic        sb_full;
  logic        sb_empty;
  logic        overflow;
  logic        load_busy;
  logic [1:0]  proc2Dmem_command;
  logic [1:0]  proc2Dmem_size;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2Dmem_data;
  logic [3:0]  Dmem2proc_response;
  logic [31:0] lookup_addr;
  logic [1:0]  lookup_size;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic        lookup_conflict;

  int n_checks = 0;
  int n_bad    = 0;

  store_drain_buffer #(.DEPTH(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .ret_command        (ret_command),
    .ret_size           (ret_size),
    .ret_addr           (ret_addr),
    .ret_data           (ret_data),
    .sb_full            (sb_full),
    .sb_empty           (sb_empty),
    .overflow           (overflow),
    .load_busy          (load_busy),
    .proc2Dmem_command  (proc2Dmem_command),
    .proc2Dmem_size     (proc2Dmem_size),
    .proc2Dmem_addr     (proc2Dmem_addr),
    .proc2Dmem_data     (proc2Dmem_data),
    .Dmem2proc_response (Dmem2proc_response),
    .lookup_addr        (lookup_addr),
    .lookup_size        (lookup_size),
    .lookup_hit         (lookup_hit),
    .lookup_data        (lookup_data),
    .lookup_conflict    (lookup_conflict)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    ret_command        = BUS_NONE;
    ret_size           = '0;
    ret_addr           = '0;
    ret_data           = '0;
    load_busy          = 1'b0;
    Dmem2proc_response = 4'h0;
    lookup_addr        = '0;
    lookup_size        = '0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_empty", sb_empty, 1);
    check("rst_full", sb_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cmd", proc2Dmem_command, BUS_NONE);
    check("rst_addr", proc2Dmem_addr, 0);
    check("rst_data", proc2Dmem_data, 0);
    check("rst_conflict", lookup_conflict, 0);
    check("rst_hit", lookup_hit, 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // driver: present one retire store at this negedge, latched on the next posedge
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    ret_command = BUS_STORE;
    ret_addr    = a;
    ret_data    = d;
    ret_size    = sz;
    @(negedge clock);
    ret_command = BUS_NONE;
  endtask

  initial begin
    reset              = 1'b0;
    ret_command        = BUS_NONE;
    ret_size           = '0;
    ret_addr           = '0;
    ret_data           = '0;
    load_busy          = 1'b0;
    Dmem2proc_response = 4'h0;
    lookup_addr        = '0;
    lookup_size        = '0;

    // single store, memory always accepts
    do_reset();
    Dmem2proc_response = 4'h1;
    ret_command = BUS_STORE; ret_addr = 32'h100; ret_data = 32'hDEAD; ret_size = SZ_WORD;
    #1;
    check("t1_lat_cmd", proc2Dmem_command, BUS_NONE);
    @(negedge clock);
    ret_command = BUS_NONE;
    #1;
    check("t1_cmd", proc2Dmem_command, BUS_STORE);
    check("t1_addr", proc2Dmem_addr, 32'h100);
    check("t1_data", proc2Dmem_data, 32'hDEAD);
    check("t1_size", proc2Dmem_size, SZ_WORD);
    check("t1_busy_empty", sb_empty, 0);
    @(negedge clock);
    #1;
    check("t1_done_cmd", proc2Dmem_command, BUS_NONE);
    check("t1_done_empty", sb_empty, 1);

    // fill with no accept, overflow, head held
    do_reset();
    Dmem2proc_response = 4'h0;
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4*i), 32'hA0 + 32'(i), SZ_WORD);
    #1;
    check("t2_full", sb_full, 1);
    check("t2_ovf_pre", overflow, 0);
    push(32'h110, 32'hBB, SZ_WORD);
    #1;
    check("t2_ovf", overflow, 1);
    check("t2_full2", sb_full, 1);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t2_hold_cmd", proc2Dmem_command, BUS_STORE);
      check("t2_hold_addr", proc2Dmem_addr, 32'h100);
      check("t2_hold_data", proc2Dmem_data, 32'hA0);
      @(negedge clock);
    end
    Dmem2proc_response = 4'h3;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_drain_addr", proc2Dmem_addr, 32'h100 + 32'(4*i));
      check("t2_drain_data", proc2Dmem_data, 32'hA0 + 32'(i));
      @(negedge clock);
    end
    #1;
    check("t2_empty", sb_empty, 1);
    check("t2_ovf_sticky", overflow, 1);

    // load unit owns the bus
    do_reset();
    Dmem2proc_response = 4'h1;
    load_busy = 1'b1;
    push(32'h100, 32'h1, SZ_WORD);
    push(32'h104, 32'h2, SZ_WORD);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_busy_cmd", proc2Dmem_command, BUS_NONE);
      check("t3_busy_empty", sb_empty, 0);
      @(negedge clock);
    end
    load_busy = 1'b0;
    #1;
    check("t3_first_cmd", proc2Dmem_command, BUS_STORE);
    check("t3_first_addr", proc2Dmem_addr, 32'h100);
    @(negedge clock);
    #1;
    check("t3_second_cmd", proc2Dmem_command, BUS_STORE);
    check("t3_second_addr", proc2Dmem_addr, 32'h104);
    @(negedge clock);
    #1;
    check("t3_empty", sb_empty, 1);
    check("t3_idle_cmd", proc2Dmem_command, BUS_NONE);

    // store arrives while full, same-cycle accept
    do_reset();
    Dmem2proc_response = 4'h0;
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4*i), 32'hC0 + 32'(i), SZ_WORD);
    ret_command = BUS_STORE; ret_addr = 32'h200; ret_data = 32'hEE; ret_size = SZ_WORD;
    Dmem2proc_response = 4'h1;
    #1;
    check("t4_full_pre", sb_full, 1);
    @(negedge clock);
    ret_command = BUS_NONE;
    Dmem2proc_response = 4'h0;
    #1;
    check("t4_ovf", overflow, 1);
    check("t4_full_post", sb_full, 0);
    check("t4_empty_post", sb_empty, 0);
    Dmem2proc_response = 4'h1;
    for (int i = 1; i < 4; i++) begin
      #1;
      check("t4_drain_addr", proc2Dmem_addr, 32'h100 + 32'(4*i));
      @(negedge clock);
    end
    #1;
    check("t4_dropped_empty", sb_empty, 1);

    // lookup
    do_reset();
    Dmem2proc_response = 4'h0;
    push(32'h200, 32'h11, SZ_WORD);
    push(32'h200, 32'h22, SZ_WORD);
    lookup_addr = 32'h200; lookup_size = SZ_WORD;
    #1;
`ifdef STORE_FWD_EN
    check("t5_hit", lookup_hit, 1);
    check("t5_data", lookup_data, 32'h22);
    check("t5_noconf", lookup_conflict, 0);
    lookup_addr = 32'h202; lookup_size = SZ_HALF;
    #1;
    check("t5_part_conf", lookup_conflict, 1);
    check("t5_part_hit", lookup_hit, 0);
    lookup_addr = 32'h1FC; lookup_size = SZ_WORD;
    #1;
    check("t5_adj_conf", lookup_conflict, 0);
    check("t5_adj_hit", lookup_hit, 0);
`else
    check("t5_hit", lookup_hit, 0);
    check("t5_data", lookup_data, 0);
    check("t5_conf", lookup_conflict, 1);
    lookup_addr = 32'h300;
    #1;
    check("t5_far_conf", lookup_conflict, 1);
`endif

    // async reset mid-drain
    do_reset();
    Dmem2proc_response = 4'h0;
    for (int i = 0; i < 3; i++) push(32'h400 + 32'(4*i), 32'h5 + 32'(i), SZ_WORD);
    Dmem2proc_response = 4'h1;
    #1;
    check("t6_pre_cmd", proc2Dmem_command, BUS_STORE);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_cmd", proc2Dmem_command, BUS_NONE);
    check("t6_rst_empty", sb_empty, 1);
    check("t6_rst_addr", proc2Dmem_addr, 0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_after_cmd", proc2Dmem_command, BUS_NONE);
      check("t6_after_empty", sb_empty, 1);
      @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
